// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO feeding a UART serializer through a handoff FSM.
// Optional macro UART_TXQ_LEVEL_EN adds the registered fill-count port level.
module uart_tx_queue #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [7:0]   wr_data,
   input  logic         wr_vld,
   output logic         wr_rdy,
   input  logic         tx_rdy,
   output logic [7:0]   tx_data,
   output logic         tx_vld,
   output logic         empty,
   output logic         busy,
`ifdef UART_TXQ_LEVEL_EN
   output logic         ovf_err,
   output logic [AW:0]  level
`else
   output logic         ovf_err
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      WAIT_ACK,
      WAIT_DONE
   } state_t;

   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [1:0]    tmo;
   state_t        state;
   logic          full;
   logic          push;
   logic          pop;

   assign full   = (count == FULL_CNT);
   assign empty  = (count == '0);
   assign wr_rdy = !full;
   assign busy   = (state != IDLE);
   assign push   = wr_vld && !full;
   assign pop    = (state == IDLE) && !empty && tx_rdy;

`ifdef UART_TXQ_LEVEL_EN
   assign level = count;
`endif

   // Storage write; contents are left as-is across reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers and fill count; simultaneous push and pop cancel.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sticky overflow flag: a write attempt while full.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_err <= 1'b0;
      end else if (wr_vld && full) begin
         ovf_err <= 1'b1;
      end
   end

   // Handoff FSM; tx_vld is registered so it never follows tx_rdy
   // combinationally (the serializer's rdy depends on din_vld).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         tx_data <= '0;
         tx_vld  <= 1'b0;
         tmo     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               tx_vld <= 1'b0;
               tmo    <= '0;
               if (pop) begin
                  tx_data <= mem[rd_ptr];
                  tx_vld  <= 1'b1;
                  state   <= LOAD;
               end
            end
            LOAD: begin
               tx_vld <= 1'b0;
               tmo    <= '0;
               state  <= WAIT_ACK;
            end
            WAIT_ACK: begin
               tx_vld <= 1'b0;
               if (!tx_rdy) begin
                  state <= WAIT_DONE;
               end else if (tmo == 2'd3) begin
                  state <= IDLE;
               end else begin
                  tmo <= tmo + 1'b1;
               end
            end
            WAIT_DONE: begin
               tx_vld <= 1'b0;
               if (tx_rdy) begin
                  state <= IDLE;
               end
            end
            default: begin
               tx_vld <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: directed tests for uart_tx_queue with a serializer model.
// Serializer model: BPS=16, 10-bit frame, rdy = idle.
module tb_uart_tx_queue;

   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int BPS   = 16;
   localparam int FRAME = 10 * BPS;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [7:0]    wr_data;
   logic          wr_vld;
   logic          wr_rdy;
   logic          tx_rdy;
   logic [7:0]    tx_data;
   logic          tx_vld;
   logic          empty;
   logic          busy;
   logic          ovf_err;
`ifdef UART_TXQ_LEVEL_EN
   logic [AW:0]   level;
`endif

   int checks   = 0;
   int failures = 0;

   logic   ser_en  = 1'b0;
   logic   man_rdy = 1'b0;
   int     ser_cnt = 0;
   int     cyc     = 0;
   int     vld_count = 0;
   logic [7:0] cap_q [$];
   int         cap_cyc [$];

   assign tx_rdy = ser_en ? (ser_cnt == 0) : man_rdy;

   always #5 clk = ~clk;

   uart_tx_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_data (wr_data),
      .wr_vld  (wr_vld),
      .wr_rdy  (wr_rdy),
      .tx_rdy  (tx_rdy),
      .tx_data (tx_data),
      .tx_vld  (tx_vld),
      .empty   (empty),
      .busy    (busy),
`ifdef UART_TXQ_LEVEL_EN
      .ovf_err (ovf_err),
      .level   (level)
`else
      .ovf_err (ovf_err)
`endif
   );

   // Cycle counter and tx_vld pulse counter.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (tx_vld) vld_count <= vld_count + 1;
   end

   // Serializer model: latch din on din_vld when idle, then busy one frame.
   always @(posedge clk) begin
      if (!ser_en) begin
         ser_cnt <= 0;
      end else if (tx_vld && ser_cnt == 0) begin
         ser_cnt <= FRAME;
         cap_q.push_back(tx_data);
         cap_cyc.push_back(cyc);
      end else if (ser_cnt != 0) begin
         ser_cnt <= ser_cnt - 1;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      ser_en  = 1'b0;
      man_rdy = 1'b0;
      wr_vld  = 1'b0;
      wr_data = 8'h00;
      rst_n   = 1'b0;
      tick(2);
      rst_n = 1'b1;
      cap_q.delete();
      cap_cyc.delete();
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (empty !== 1'b1 || wr_rdy !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags empty=%b wr_rdy=%b busy=%b want 1 1 0",
                  empty, wr_rdy, busy);
      end
      checks++;
      if (tx_vld !== 1'b0 || tx_data !== 8'h00 || ovf_err !== 1'b0) begin
         failures++;
         $display("FAIL reset_tx tx_vld=%b tx_data=%h ovf=%b want 0 00 0",
                  tx_vld, tx_data, ovf_err);
      end
`ifdef UART_TXQ_LEVEL_EN
      checks++;
      if (level !== '0) begin
         failures++;
         $display("FAIL reset_level got=%0d want=0", level);
      end
`endif
   endtask

   task automatic test_single();
      int v0;
      do_reset();
      man_rdy = 1'b1;
      v0 = vld_count;
      wr_data = 8'h55;
      wr_vld  = 1'b1;
      tick();
      wr_vld = 1'b0;
      checks++;
      if (empty !== 1'b0 || tx_vld !== 1'b0) begin
         failures++;
         $display("FAIL single_c1 empty=%b tx_vld=%b want 0 0", empty, tx_vld);
      end
      tick();
      checks++;
      if (tx_vld !== 1'b1 || tx_data !== 8'h55 || busy !== 1'b1
          || empty !== 1'b1) begin
         failures++;
         $display("FAIL single_load tx_vld=%b data=%h busy=%b empty=%b want 1 55 1 1",
                  tx_vld, tx_data, busy, empty);
      end
      tick();
      man_rdy = 1'b0;
      checks++;
      if (tx_vld !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL single_ack tx_vld=%b busy=%b want 0 1", tx_vld, busy);
      end
      tick(3);
      checks++;
      if (busy !== 1'b1 || tx_data !== 8'h55) begin
         failures++;
         $display("FAIL single_wait busy=%b data=%h want 1 55", busy, tx_data);
      end
      man_rdy = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0 || empty !== 1'b1 || vld_count - v0 !== 1) begin
         failures++;
         $display("FAIL single_done busy=%b empty=%b pulses=%0d want 0 1 1",
                  busy, empty, vld_count - v0);
      end
   endtask

   task automatic test_timeout();
      int ok;
      do_reset();
      wr_vld = 1'b1;
      wr_data = 8'hA1;
      tick();
      wr_data = 8'hA2;
      tick();
      wr_vld = 1'b0;
      man_rdy = 1'b1;
      tick();
      checks++;
      if (tx_vld !== 1'b1 || tx_data !== 8'hA1) begin
         failures++;
         $display("FAIL tmo_load1 tx_vld=%b data=%h want 1 a1", tx_vld, tx_data);
      end
      ok = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (busy !== 1'b1 || tx_vld !== 1'b0) ok = 0;
      end
      checks++;
      if (ok != 1) begin
         failures++;
         $display("FAIL tmo_hold busy/tx_vld wrong during 4 wait cycles got=0 want=1");
      end
      tick();
      checks++;
      if (busy !== 1'b0 || ovf_err !== 1'b0) begin
         failures++;
         $display("FAIL tmo_idle busy=%b ovf=%b want 0 0", busy, ovf_err);
      end
      tick();
      checks++;
      if (tx_vld !== 1'b1 || tx_data !== 8'hA2) begin
         failures++;
         $display("FAIL tmo_next tx_vld=%b data=%h want 1 a2", tx_vld, tx_data);
      end
   endtask

   task automatic test_overflow();
      int n;
      do_reset();
      for (int i = 1; i <= DEPTH; i++) begin
         wr_data = 8'(i);
         wr_vld  = 1'b1;
         tick();
      end
      checks++;
      if (wr_rdy !== 1'b0 || ovf_err !== 1'b0) begin
         failures++;
         $display("FAIL ovf_full wr_rdy=%b ovf=%b want 0 0", wr_rdy, ovf_err);
      end
      wr_data = 8'hAA;
      tick(3);
      wr_vld = 1'b0;
      checks++;
      if (ovf_err !== 1'b1 || wr_rdy !== 1'b0) begin
         failures++;
         $display("FAIL ovf_set ovf=%b wr_rdy=%b want 1 0", ovf_err, wr_rdy);
      end
`ifdef UART_TXQ_LEVEL_EN
      checks++;
      if (level !== 5'd16) begin
         failures++;
         $display("FAIL ovf_level got=%0d want=16", level);
      end
`endif
      tick(4);
      checks++;
      if (ovf_err !== 1'b1) begin
         failures++;
         $display("FAIL ovf_sticky ovf=%b want 1", ovf_err);
      end
      ser_en = 1'b1;
      n = 0;
      while (cap_q.size() < DEPTH && n < DEPTH * (FRAME + 20)) begin
         tick();
         n++;
      end
      checks++;
      if (cap_q.size() != DEPTH) begin
         failures++;
         $display("FAIL ovf_drain_timeout got=%0d want=%0d", cap_q.size(), DEPTH);
      end else begin
         n = 0;
         for (int i = 0; i < DEPTH; i++)
            if (cap_q[i] !== 8'(i + 1)) n++;
         if (n != 0) begin
            failures++;
            $display("FAIL ovf_drain_order bad_bytes got=%0d want=0", n);
         end
      end
      checks++;
      if (ovf_err !== 1'b1) begin
         failures++;
         $display("FAIL ovf_after_drain ovf=%b want 1", ovf_err);
      end
   endtask

   task automatic test_burst();
      int n;
      int acc;
      do_reset();
      ser_en = 1'b1;
      acc = 0;
      for (int i = 1; i <= DEPTH; i++) begin
         if (wr_rdy === 1'b1) acc++;
         wr_data = 8'(i);
         wr_vld  = 1'b1;
         tick();
      end
      wr_vld = 1'b0;
      checks++;
      if (acc != DEPTH) begin
         failures++;
         $display("FAIL burst_accept got=%0d want=%0d", acc, DEPTH);
      end
      n = 0;
      while (cap_q.size() < DEPTH && n < DEPTH * (FRAME + 20)) begin
         tick();
         n++;
      end
      checks++;
      if (cap_q.size() != DEPTH) begin
         failures++;
         $display("FAIL burst_timeout got=%0d want=%0d", cap_q.size(), DEPTH);
      end else begin
         n = 0;
         for (int i = 0; i < DEPTH; i++)
            if (cap_q[i] !== 8'(i + 1)) n++;
         if (n != 0) begin
            failures++;
            $display("FAIL burst_order bad_bytes got=%0d want=0", n);
         end
      end
      checks++;
      n = 0;
      for (int i = 1; i < cap_cyc.size(); i++)
         if (cap_cyc[i] - cap_cyc[i-1] != FRAME + 3) n++;
      if (n != 0 || cap_cyc.size() != DEPTH) begin
         failures++;
         $display("FAIL burst_spacing bad_gaps got=%0d want=0 (gap %0d)",
                  n, FRAME + 3);
      end
   endtask

   task automatic test_wrap();
      int k;
      int n;
      int bad;
      int grp;
      do_reset();
      ser_en = 1'b1;
      k = 0;
      bad = 0;
      while (k < 40) begin
         grp = (40 - k < 3) ? 40 - k : 3;
         for (int j = 0; j < grp; j++) begin
            wr_data = 8'((k + j) * 37 + 5);
            wr_vld  = 1'b1;
            tick();
         end
         wr_vld = 1'b0;
         k += grp;
         n = 0;
         while ((cap_q.size() < k || busy !== 1'b0) && n < 4 * (FRAME + 20)) begin
            tick();
            n++;
         end
         if (cap_q.size() != k || empty !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL wrap_groups bad_groups got=%0d want=0", bad);
      end
      checks++;
      n = 0;
      for (int i = 0; i < cap_q.size(); i++)
         if (cap_q[i] !== 8'(i * 37 + 5)) n++;
      if (n != 0 || cap_q.size() != 40) begin
         failures++;
         $display("FAIL wrap_order bad=%0d count=%0d want 0 40", n, cap_q.size());
      end
      tick(5);
      checks++;
      if (empty !== 1'b1 || wr_rdy !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL wrap_final empty=%b wr_rdy=%b busy=%b want 1 1 0",
                  empty, wr_rdy, busy);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      int v0;
      do_reset();
      ser_en = 1'b1;
      v0 = vld_count;
      for (int i = 0; i < 6; i++) begin
         wr_data = 8'(8'hC0 + i);
         wr_vld  = 1'b1;
         tick();
      end
      wr_vld = 1'b0;
      n = 0;
      while (vld_count == v0 && n < 50) begin
         tick();
         n++;
      end
      tick(20);
      checks++;
      if (busy !== 1'b1 || empty !== 1'b0 || vld_count - v0 != 1) begin
         failures++;
         $display("FAIL rmid_pre busy=%b empty=%b pulses=%0d want 1 0 1",
                  busy, empty, vld_count - v0);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++;
      if (busy !== 1'b0 || empty !== 1'b1 || tx_vld !== 1'b0 || wr_rdy !== 1'b1) begin
         failures++;
         $display("FAIL rmid_post busy=%b empty=%b tx_vld=%b wr_rdy=%b want 0 1 0 1",
                  busy, empty, tx_vld, wr_rdy);
      end
      v0 = vld_count;
      tick(2 * FRAME + 40);
      checks++;
      if (vld_count != v0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL rmid_quiet pulses=%0d busy=%b want 0 0",
                  vld_count - v0, busy);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      wr_vld  = 1'b0;
      wr_data = 8'h00;
      test_reset();
      test_single();
      test_timeout();
      test_overflow();
      test_burst();
      test_wrap();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16 (power of 2, 2..256): FIFO entries.
REQ-002 The block SHALL have parameter AW, default 4 (log2(DEPTH)): FIFO pointer width.
REQ-003 The block SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1: reset, synchronous and active-low.
REQ-005 The block SHALL have port wr_data  input  8: byte from the producer.
REQ-006 The block SHALL have port wr_vld  input  1: producer offers wr_data this cycle.
REQ-007 The block SHALL have port wr_rdy  output  1: queue accepts a byte this cycle (= not full).
REQ-008 The block SHALL have port tx_rdy  input  1: serializer idle, wired to the serializer's rdy.
REQ-009 The block SHALL have port tx_data  output  8: byte to the serializer's din.
REQ-010 The block SHALL have port tx_vld  output  1: start-send pulse to the serializer's din_vld.
REQ-011 The block SHALL have port empty  output  1: FIFO holds no bytes.
REQ-012 The block SHALL have port busy  output  1: a byte is being handed off or transmitted (state != IDLE).
REQ-013 The block SHALL have port ovf_err  output  1: sticky; wr_vld seen while full.

Function
REQ-014 Push: wr_vld && wr_rdy SHALL write wr_data at the write pointer; pointer wraps DEPTH-1 -> 0.
REQ-015 wr_rdy SHALL be !full, registered-state derived; a push while full is blocked even if a pop occurs the same cycle.
REQ-016 Fill count SHALL be AW+1 bits: +1 on push only, -1 on pop only, unchanged on push and pop together; full = (count==DEPTH), empty = (count==0).
REQ-017 The FSM SHALL have states IDLE, LOAD, WAIT_ACK and WAIT_DONE; reset state IDLE.
REQ-018 In IDLE with !empty && tx_rdy, the block SHALL pop the head into registered tx_data and go to LOAD; a byte pushed into an empty FIFO is eligible one cycle later.
REQ-019 In LOAD, tx_vld SHALL be 1 for exactly that one cycle, and the FSM SHALL go to WAIT_ACK.
REQ-020 In WAIT_ACK, the FSM SHALL stay until tx_rdy==0, then go to WAIT_DONE.
REQ-021 WAIT_ACK SHALL time out after 4 cycles with tx_rdy still 1 and return to IDLE; the byte is lost and ovf_err is not set.
REQ-022 In WAIT_DONE, the FSM SHALL stay until tx_rdy==1, then go to IDLE; the next pop is earliest on the following cycle.
REQ-023 tx_data SHALL be held stable from LOAD until the next pop.
REQ-024 tx_vld SHALL be a register output and SHALL never depend combinationally on tx_rdy, because the serializer's rdy depends combinationally on din_vld.
REQ-025 ovf_err SHALL be set on wr_vld && full and cleared only by reset.
REQ-026 Minimum byte-to-byte start spacing SHALL be one serializer frame + 3 cycles.

Reset
REQ-027 When rst_n==0 at a clk edge, the block SHALL go to IDLE and set pointers/count=0, tx_vld=0, tx_data=0, ovf_err=0, empty=1, wr_rdy=1, busy=0.
REQ-028 Reset mid-transfer SHALL drop all queued bytes; FIFO RAM contents need not be cleared.

Configuration
REQ-029 Macro UART_TXQ_LEVEL_EN defined: the block SHALL add output port level [AW:0], equal to the registered fill count.
REQ-030 Macro UART_TXQ_LEVEL_EN undefined: port level and any logic dedicated to it SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-031 Single byte: push 0x55 into an empty queue with tx_rdy=1 -> tx_vld pulses once 2 cycles later with tx_data=0x55; busy until tx_rdy returns; empty=1 afterwards.
REQ-032 Burst: push 0x01..0x10 back-to-back with DEPTH=16 and the serializer (BPS=16) attached -> all 16 accepted, wr_rdy low while full, serial output carries 0x01..0x10 in order with no gaps beyond REQ-026.
REQ-033 Overflow: with the FIFO full and tx_rdy held 0, hold wr_vld=1 with 0xAA -> no write, ovf_err=1 and stays 1, count stays 16.
REQ-034 Pointer wrap: push and pop 40 bytes in total, never exceeding 3 occupied -> output order matches input and the count never underflows.
REQ-035 Reset mid-frame: assert rst_n=0 for 1 cycle during WAIT_DONE with 5 bytes queued -> next cycle IDLE, empty=1, tx_vld=0, and no further tx_vld.
REQ-036 Timeout: tx_rdy stuck at 1 after LOAD -> return to IDLE after 4 cycles, and the next queued byte is issued.
